// File: rtl/modbus_uart_if.sv
// Byte-level handshake between modbus_uart and the Modbus RTU slave core.
// The slave modport is the UART side; the master modport is the core side.
interface modbus_uart_if;
  logic       rxv;
  logic [7:0] rxd;
  logic       ferr;
  logic       eof;
  logic       perr;
  logic       txv;
  logic [7:0] txd;
  logic       cts;

  modport master (
    input  rxv, rxd, ferr, eof, perr, cts,
    output txv, txd
  );

  modport slave (
    output rxv, rxd, ferr, eof, perr, cts,
    input  txv, txd
  );
endinterface

// File: rtl/modbus_uart.sv
// Serial UART (8N1) feeding the Modbus RTU slave core, with t3.5 end-of-frame detector.
// Define MODBUS_UART_PARITY_EN for 8E1 framing: even parity generated on TX, checked on RX (perr).
module modbus_uart #(
  parameter int PRESCALER = 100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  output logic         tx,
  modbus_uart_if.slave bus
);

  localparam int CW = $clog2(39 * PRESCALER + 1);
`ifdef MODBUS_UART_PARITY_EN
  localparam int EOF_CYCLES = 39 * PRESCALER;
`else
  localparam int EOF_CYCLES = 35 * PRESCALER;
`endif
  localparam logic [CW-1:0] BIT_LAST  = CW'(PRESCALER - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(PRESCALER / 2 - 1);
  localparam logic [CW-1:0] EOF_LAST  = CW'(EOF_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [2:0] R_IDLE  = 3'd0;
  localparam logic [2:0] R_START = 3'd1;
  localparam logic [2:0] R_DATA  = 3'd2;
  localparam logic [2:0] R_STOP  = 3'd4;
  localparam logic [2:0] T_IDLE  = 3'd0;
  localparam logic [2:0] T_START = 3'd1;
  localparam logic [2:0] T_DATA  = 3'd2;
  localparam logic [2:0] T_STOP  = 3'd4;
`ifdef MODBUS_UART_PARITY_EN
  localparam logic [2:0] R_PAR   = 3'd3;
  localparam logic [2:0] T_PAR   = 3'd3;
`endif

  logic          rx_meta;
  logic          rs;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bits;
  logic [7:0]    r_shift;
  logic          r_brk;
  logic [CW-1:0] sil_cnt;
  logic          armed;
  logic [2:0]    t_state;
  logic [CW-1:0] t_cnt;
  logic [2:0]    t_bits;
  logic [7:0]    t_shift;
  logic          ready;
`ifdef MODBUS_UART_PARITY_EN
  logic          r_perr;
  logic          t_par;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rs      <= 1'b1;
    end else begin
      rx_meta <= rx;
      rs      <= rx_meta;
    end
  end

  // Receiver: samples mid-bit and returns to idle at mid-stop so gapless bytes are caught.
  // After a framing error it parks in R_STOP (r_brk) until the line goes high again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= R_IDLE;
      r_cnt    <= '0;
      r_bits   <= '0;
      r_shift  <= '0;
      r_brk    <= 1'b0;
      bus.rxv  <= 1'b0;
      bus.rxd  <= '0;
      bus.ferr <= 1'b0;
`ifdef MODBUS_UART_PARITY_EN
      r_perr   <= 1'b0;
      bus.perr <= 1'b0;
`endif
    end else begin
      bus.rxv  <= 1'b0;
      bus.ferr <= 1'b0;
`ifdef MODBUS_UART_PARITY_EN
      bus.perr <= 1'b0;
`endif
      case (r_state)
        R_IDLE: begin
          if (!rs) begin
            r_state <= R_START;
            r_cnt   <= HALF_LAST;
          end
        end
        R_START: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else if (rs) begin
            r_state <= R_IDLE;
          end else begin
            r_state <= R_DATA;
            r_cnt   <= BIT_LAST;
            r_bits  <= '0;
          end
        end
        R_DATA: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            r_shift <= {rs, r_shift[7:1]};
            r_cnt   <= BIT_LAST;
            r_bits  <= r_bits + 3'd1;
            if (r_bits == 3'd7) begin
`ifdef MODBUS_UART_PARITY_EN
              r_state <= R_PAR;
`else
              r_state <= R_STOP;
`endif
            end
          end
        end
`ifdef MODBUS_UART_PARITY_EN
        R_PAR: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            r_perr  <= rs ^ (^r_shift);
            r_cnt   <= BIT_LAST;
            r_state <= R_STOP;
          end
        end
`endif
        R_STOP: begin
          if (r_brk) begin
            if (rs) begin
              r_brk   <= 1'b0;
              r_state <= R_IDLE;
            end
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else if (rs) begin
            bus.rxv <= 1'b1;
            bus.rxd <= r_shift;
`ifdef MODBUS_UART_PARITY_EN
            bus.perr <= r_perr;
`endif
            r_state <= R_IDLE;
          end else begin
            bus.ferr <= 1'b1;
            r_brk    <= 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

`ifndef MODBUS_UART_PARITY_EN
  assign bus.perr = 1'b0;
`endif

  // t3.5 silence detector: counts idle-high cycles, restarts on any start edge, and
  // fires once per completed frame when the count reaches the threshold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sil_cnt <= '0;
      armed   <= 1'b0;
      bus.eof <= 1'b0;
    end else begin
      bus.eof <= 1'b0;
      if (r_state == R_IDLE && !rs) begin
        sil_cnt <= '0;
      end else if (r_state == R_IDLE && sil_cnt != EOF_LAST) begin
        sil_cnt <= sil_cnt + CNT_ONE;
      end
      if (bus.rxv || bus.ferr) begin
        armed <= 1'b1;
      end else if (armed && sil_cnt == EOF_LAST) begin
        bus.eof <= 1'b1;
        armed   <= 1'b0;
      end
    end
  end

  // Transmitter: the stop bit hands back to T_IDLE one cycle early so a txv taken
  // in that idle cycle follows with no gap, keeping each byte exactly one frame long.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_state <= T_IDLE;
      t_cnt   <= '0;
      t_bits  <= '0;
      t_shift <= '0;
      tx      <= 1'b1;
      ready   <= 1'b0;
`ifdef MODBUS_UART_PARITY_EN
      t_par   <= 1'b0;
`endif
    end else begin
      ready <= 1'b1;
      case (t_state)
        T_IDLE: begin
          if (bus.txv && bus.cts) begin
            t_shift <= bus.txd;
`ifdef MODBUS_UART_PARITY_EN
            t_par   <= ^bus.txd;
`endif
            tx      <= 1'b0;
            t_cnt   <= BIT_LAST;
            t_state <= T_START;
          end
        end
        T_START: begin
          if (t_cnt != '0) begin
            t_cnt <= t_cnt - CNT_ONE;
          end else begin
            tx      <= t_shift[0];
            t_shift <= {1'b0, t_shift[7:1]};
            t_cnt   <= BIT_LAST;
            t_bits  <= '0;
            t_state <= T_DATA;
          end
        end
        T_DATA: begin
          if (t_cnt != '0) begin
            t_cnt <= t_cnt - CNT_ONE;
          end else begin
            t_cnt <= BIT_LAST;
            if (t_bits == 3'd7) begin
`ifdef MODBUS_UART_PARITY_EN
              tx      <= t_par;
              t_state <= T_PAR;
`else
              tx      <= 1'b1;
              t_state <= T_STOP;
`endif
            end else begin
              tx      <= t_shift[0];
              t_shift <= {1'b0, t_shift[7:1]};
              t_bits  <= t_bits + 3'd1;
            end
          end
        end
`ifdef MODBUS_UART_PARITY_EN
        T_PAR: begin
          if (t_cnt != '0) begin
            t_cnt <= t_cnt - CNT_ONE;
          end else begin
            tx      <= 1'b1;
            t_cnt   <= BIT_LAST;
            t_state <= T_STOP;
          end
        end
`endif
        T_STOP: begin
          if (t_cnt != CNT_ONE) begin
            t_cnt <= t_cnt - CNT_ONE;
          end else begin
            t_state <= T_IDLE;
          end
        end
        default: t_state <= T_IDLE;
      endcase
    end
  end

  assign bus.cts = ready && (t_state == T_IDLE);

endmodule

// File: tb/tb_modbus_uart.sv
// Self-checking bench for modbus_uart (PRESCALER=8); received bytes are scoreboarded.
// Build with MODBUS_UART_PARITY_EN defined to exercise 8E1 framing and perr.
module tb_modbus_uart;
  localparam int P = 8;
`ifdef MODBUS_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam int EOF_T      = 39 * P;
`else
  localparam int FRAME_BITS = 10;
  localparam int EOF_T      = 35 * P;
`endif
  localparam int LEN = FRAME_BITS * P;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rx_drv;
  logic loop_en;
  logic tx;
  logic rx;

  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  int   rxv_count = 0;
  int   ferr_count = 0;
  int   eof_count = 0;
  int   perr_count = 0;
  int   last_rxv_cycle = 0;
  int   last_eof_cycle = 0;
  logic prev_rxv = 1'b0;
  logic prev_ferr = 1'b0;
  logic prev_eof = 1'b0;
  exp_t exp_q[$];
  exp_t e;

  modbus_uart_if bus ();

  modbus_uart #(.PRESCALER(P)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .tx  (tx),
    .bus (bus.slave)
  );

  assign rx = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: pops the scoreboard on every rxv and checks that strobes last one cycle.
  always @(negedge clk) begin
    if (bus.rxv === 1'b1) begin
      rxv_count++;
      last_rxv_cycle = cycle;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL rx_unexpected: got rxd=%02h, required no byte", bus.rxd);
      end else begin
        e = exp_q.pop_front();
        if (bus.rxd !== e.d || bus.perr !== e.p || bus.ferr !== 1'b0) begin
          failures++;
          $display("[TB] FAIL rx_byte: got rxd=%02h perr=%b ferr=%b, required rxd=%02h perr=%b ferr=0",
                   bus.rxd, bus.perr, bus.ferr, e.d, e.p);
        end
      end
    end
    if (bus.ferr === 1'b1) ferr_count++;
    if (bus.perr === 1'b1) perr_count++;
    if (bus.eof === 1'b1) begin
      eof_count++;
      last_eof_cycle = cycle;
    end
    if (bus.rxv === 1'b1 || bus.ferr === 1'b1 || bus.eof === 1'b1 || bus.perr === 1'b1) begin
      checks++;
      if ((bus.rxv && prev_rxv) || (bus.ferr && prev_ferr) || (bus.eof && prev_eof) ||
          (bus.perr && !bus.rxv)) begin
        failures++;
        $display("[TB] FAIL strobe_shape: got rxv=%b/%b ferr=%b/%b eof=%b/%b perr=%b, required single-cycle strobes",
                 prev_rxv, bus.rxv, prev_ferr, bus.ferr, prev_eof, bus.eof, bus.perr);
      end
    end
    prev_rxv  = bus.rxv;
    prev_ferr = bus.ferr;
    prev_eof  = bus.eof;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic tx_bit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
`ifdef MODBUS_UART_PARITY_EN
    if (pos == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input logic flip);
    rx_drv = 1'b0;
    repeat (P) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (P) @(negedge clk);
    end
`ifdef MODBUS_UART_PARITY_EN
    rx_drv = (^b) ^ flip;
    repeat (P) @(negedge clk);
`else
    if (flip) $display("[TB] parity flip ignored in 8N1 build");
`endif
    rx_drv = stop_bit;
    repeat (P) @(negedge clk);
  endtask

  task automatic wait_cts(input string tag);
    int n = 0;
    while (bus.cts !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.cts !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s_cts_timeout: got cts=%b after %0d cycles, required 1", tag, bus.cts, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_tx: got %b, required 1", tx);
    end
    checks++;
    if (bus.cts !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_cts: got %b, required 0", bus.cts);
    end
    checks++;
    if ({bus.rxv, bus.ferr, bus.eof, bus.perr} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_strobes: got rxv/ferr/eof/perr=%b, required 0000",
               {bus.rxv, bus.ferr, bus.eof, bus.perr});
    end
    checks++;
    if (bus.rxd !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_rxd: got %02h, required 00", bus.rxd);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.cts !== 1'b0) begin
      failures++;
      $display("[TB] FAIL release_cts_early: got %b, required 0 before first edge", bus.cts);
    end
    @(negedge clk);
    checks++;
    if (bus.cts !== 1'b1) begin
      failures++;
      $display("[TB] FAIL release_cts: got %b, required 1 after first edge", bus.cts);
    end
  endtask

  // Two bytes in loopback: the second txv lands on the cts-rise cycle and must follow gapless;
  // a txv while busy must be dropped.
  task automatic test_tx_loopback();
    int errs = 0;
    int first_bad = -1;
    int cts_rise = -1;
    int r0;
    logic [7:0] cur;
    r0 = rxv_count;
    loop_en = 1'b1;
    wait_cts("tx_a5");
    exp_q.push_back('{d: 8'hA5, p: 1'b0});
    bus.txd = 8'hA5;
    bus.txv = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2 * LEN; i++) begin
      cur = (i < LEN) ? 8'hA5 : 8'h3C;
      if (tx !== tx_bit(cur, (i % LEN) / P)) begin
        errs++;
        if (first_bad < 0) first_bad = i;
      end
      if (i < LEN && bus.cts === 1'b1 && cts_rise < 0) cts_rise = i;
      bus.txv = 1'b0;
      if (i == 30) begin
        bus.txv = 1'b1;
        bus.txd = 8'hFF;
      end
      if (i == LEN - 1 && bus.cts === 1'b1) begin
        bus.txv = 1'b1;
        bus.txd = 8'h3C;
        exp_q.push_back('{d: 8'h3C, p: 1'b0});
      end
      @(negedge clk);
    end
    bus.txv = 1'b0;
    checks++;
    if (errs != 0) begin
      failures++;
      $display("[TB] FAIL tx_stream: got %0d wrong bit samples (first at cycle %0d), required 0", errs, first_bad);
    end
    checks++;
    if (cts_rise != LEN - 1) begin
      failures++;
      $display("[TB] FAIL tx_byte_period: got cts high at cycle %0d after accept, required %0d", cts_rise, LEN - 1);
    end
    repeat (20) @(negedge clk);
    loop_en = 1'b0;
    checks++;
    if (rxv_count != r0 + 2 || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL loopback_rx: got %0d bytes (%0d pending), required 2 (0 pending)",
               rxv_count - r0, exp_q.size());
    end
  endtask

  task automatic test_rx_glitch();
    int r0, f0;
    r0 = rxv_count;
    f0 = ferr_count;
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (60) @(negedge clk);
    checks++;
    if (rxv_count != r0 || ferr_count != f0) begin
      failures++;
      $display("[TB] FAIL rx_glitch: got rxv=%0d ferr=%0d, required 0 0", rxv_count - r0, ferr_count - f0);
    end
    exp_q.push_back('{d: 8'h5A, p: 1'b0});
    drive_frame(8'h5A, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    checks++;
    if (rxv_count != r0 + 1) begin
      failures++;
      $display("[TB] FAIL rx_after_glitch: got %0d bytes, required 1", rxv_count - r0);
    end
  endtask

  task automatic test_framing_error();
    int r0, f0;
    r0 = rxv_count;
    f0 = ferr_count;
    drive_frame(8'h55, 1'b0, 1'b0);
    repeat (50) @(negedge clk);
    rx_drv = 1'b1;
    repeat (150) @(negedge clk);
    checks++;
    if (ferr_count != f0 + 1 || rxv_count != r0) begin
      failures++;
      $display("[TB] FAIL framing_error: got ferr=%0d rxv=%0d, required ferr=1 rxv=0",
               ferr_count - f0, rxv_count - r0);
    end
    exp_q.push_back('{d: 8'hC7, p: 1'b0});
    drive_frame(8'hC7, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    checks++;
    if (rxv_count != r0 + 1) begin
      failures++;
      $display("[TB] FAIL rx_after_break: got %0d bytes, required 1", rxv_count - r0);
    end
  endtask

  task automatic test_eof();
    int e0, delta;
    repeat (EOF_T + 50) @(negedge clk);
    e0 = eof_count;
    exp_q.push_back('{d: 8'h11, p: 1'b0});
    drive_frame(8'h11, 1'b1, 1'b0);
    repeat (EOF_T + 100) @(negedge clk);
    delta = last_eof_cycle - last_rxv_cycle;
    checks++;
    if (eof_count != e0 + 1) begin
      failures++;
      $display("[TB] FAIL eof_count: got %0d pulses, required 1", eof_count - e0);
    end
    checks++;
    if (delta < EOF_T - 1 || delta > EOF_T + 3) begin
      failures++;
      $display("[TB] FAIL eof_delay: got %0d cycles after rxv, required %0d..%0d", delta, EOF_T - 1, EOF_T + 3);
    end
  endtask

  task automatic test_eof_cancel();
    int e0, rcy, n, delta;
    e0 = eof_count;
    exp_q.push_back('{d: 8'h22, p: 1'b0});
    drive_frame(8'h22, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    rcy = last_rxv_cycle;
    n = 0;
    while (cycle < rcy + EOF_T - 10 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    exp_q.push_back('{d: 8'h33, p: 1'b0});
    drive_frame(8'h33, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (eof_count != e0) begin
      failures++;
      $display("[TB] FAIL eof_cancel: got %0d pulses before second frame ended, required 0", eof_count - e0);
    end
    repeat (EOF_T + 100) @(negedge clk);
    delta = last_eof_cycle - last_rxv_cycle;
    checks++;
    if (eof_count != e0 + 1 || delta < EOF_T - 1 || delta > EOF_T + 3) begin
      failures++;
      $display("[TB] FAIL eof_restart: got %0d pulses at %0d cycles after rxv, required 1 at %0d..%0d",
               eof_count - e0, delta, EOF_T - 1, EOF_T + 3);
    end
  endtask

`ifdef MODBUS_UART_PARITY_EN
  task automatic test_parity();
    int r0, p0;
    r0 = rxv_count;
    p0 = perr_count;
    exp_q.push_back('{d: 8'h3C, p: 1'b1});
    drive_frame(8'h3C, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    checks++;
    if (rxv_count != r0 + 1 || perr_count != p0 + 1) begin
      failures++;
      $display("[TB] FAIL parity_error: got rxv=%0d perr=%0d, required 1 1", rxv_count - r0, perr_count - p0);
    end
  endtask
`endif

  task automatic test_reset_mid_tx();
    int errs = 0;
    int first_bad = -1;
    loop_en = 1'b0;
    wait_cts("tx_81");
    bus.txd = 8'h81;
    bus.txv = 1'b1;
    @(negedge clk);
    bus.txv = 1'b0;
    repeat (4 * P + 4) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin
      failures++;
      $display("[TB] FAIL tx_bit4_pre_reset: got %b, required 0", tx);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || bus.cts !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_tx: got tx=%b cts=%b, required tx=1 cts=0", tx, bus.cts);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cts !== 1'b1) begin
      failures++;
      $display("[TB] FAIL cts_after_reset: got %b, required 1", bus.cts);
    end
    loop_en = 1'b1;
    exp_q.push_back('{d: 8'hC3, p: 1'b0});
    bus.txd = 8'hC3;
    bus.txv = 1'b1;
    @(negedge clk);
    bus.txv = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      if (tx !== tx_bit(8'hC3, i / P)) begin
        errs++;
        if (first_bad < 0) first_bad = i;
      end
      @(negedge clk);
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("[TB] FAIL tx_after_reset: got %0d wrong bit samples (first at cycle %0d), required 0", errs, first_bad);
    end
    repeat (20) @(negedge clk);
    loop_en = 1'b0;
  endtask

  initial begin
    rst     = 1'b0;
    rx_drv  = 1'b1;
    loop_en = 1'b0;
    bus.txv = 1'b0;
    bus.txd = 8'h00;
    $display("[TB] modbus_uart bench, PRESCALER=%0d, frame=%0d bits", P, FRAME_BITS);
    test_reset();
    test_tx_loopback();
    test_rx_glitch();
    test_framing_error();
    test_eof();
    test_eof_cancel();
`ifdef MODBUS_UART_PARITY_EN
    test_parity();
`endif
    test_reset_mid_tx();
    repeat (20) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d bytes pending, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/modbus_uart.md
Name: modbus_uart

Overview:
- 8N1 serial UART that sits directly upstream of the Modbus RTU slave core.
- Converts the RS-485 line to and from byte handshakes:
  - RX side produces the core's rxv/rxd.
  - TX side consumes the core's txv/txd and returns cts.
- Also generates the Modbus t3.5 inter-frame silence pulse (eof) used to delimit RTU frames.
- Baud timing comes from an integer clocks-per-bit prescaler shared with the core.

Parameters:
PRESCALER, 100, clock cycles per bit; legal range >= 4; one bit period = PRESCALER cycles.

Ports:
clk    input   1  system clock
rst    input   1  asynchronous, active-low reset
rx     input   1  serial line in; asynchronous to clk
tx     output  1  serial line out
rxv    output  1  one-cycle strobe, received byte valid
rxd    output  8  received byte; held until next rxv
ferr   output  1  one-cycle strobe, stop bit sampled 0
eof    output  1  one-cycle strobe, t3.5 line silence after a frame
txv    input   1  byte to transmit valid; honoured only while cts=1
txd    input   8  byte to transmit
cts    output  1  transmitter idle, ready to accept txd
perr   output  1  one-cycle strobe, parity mismatch; constant 0 unless MODBUS_UART_PARITY_EN

Behaviour:
- Reset values (rst=0, asynchronous):
  - tx=1, cts=0, rxv=0, rxd=0, ferr=0, eof=0, perr=0.
  - Both FSMs go to idle; all counters go to 0; rx synchroniser flops go to 1.
  - cts rises on the first clk edge after reset release.
  - Reset mid-frame aborts the frame: no partial rxv, tx returns to 1 immediately.
- RX synchroniser: two flops; all RX logic uses the synchronised bit rs.
- RX FSM states: R_IDLE, R_START, R_DATA, (R_PAR), R_STOP.
  - R_IDLE: rs=0 -> R_START; bit counter loaded with PRESCALER/2-1 (mid-bit).
  - R_START: on counter=0, sample rs.
    - rs=1 -> glitch, back to R_IDLE, nothing reported.
    - rs=0 -> R_DATA; counter reloaded with PRESCALER-1.
  - R_DATA: 8 samples at each counter expiry, LSB first, shifted into the register.
  - R_STOP, on counter expiry:
    - rs=1 -> rxv=1 for one cycle with rxd updated that same cycle; -> R_IDLE.
    - rs=0 -> ferr=1 for one cycle, no rxv, rxd unchanged; FSM waits for rs=1 before R_IDLE (break handling).
  - Return to R_IDLE occurs at mid-stop-bit, so back-to-back bytes with no idle gap are received.
- RX latency: rxv asserts 2 + (PRESCALER/2) + 9*PRESCALER cycles (+-1) after the rx falling edge.
- eof (t3.5 detector):
  - Silence counter increments while in R_IDLE with rs=1.
  - Cleared on every start detection.
  - Armed by any completed frame (rxv or ferr).
  - When counter reaches 35*PRESCALER (39*PRESCALER with parity) while armed: eof=1 for one cycle, then disarm.
  - Counter saturates; never wraps.
  - A start bit seen before the threshold cancels that eof.
- TX FSM states: T_IDLE, T_START, T_DATA, (T_PAR), T_STOP.
  - cts=1 only in T_IDLE.
  - txv&cts: txd latched; next cycle cts=0, state T_START, tx=0.
  - Each bit lasts exactly PRESCALER cycles; data goes out LSB first; stop bit tx=1.
  - After the stop bit completes: T_IDLE, cts=1.
  - A txv in that same cycle starts the next byte with no gap, giving 10*PRESCALER cycles per byte (11 with parity).
  - txv while cts=0 is ignored and the byte is discarded.
- RX and TX are fully independent; simultaneous activity is allowed. Half-duplex turnaround is outside this block.
- Counter width: $clog2(39*PRESCALER+1) bits.

Optional Feature:
MODBUS_UART_PARITY_EN
- Defined: 8E1 framing (Modbus default).
  - TX inserts an even parity bit (XOR of data) between data and stop.
  - RX samples the parity bit in R_PAR.
  - On mismatch, perr=1 in the same cycle as rxv; the byte is still delivered.
  - eof threshold becomes 39*PRESCALER.
- Undefined: 8N1; R_PAR/T_PAR states are absent; perr is tied to 0.

Test Plan:
- All scenarios use PRESCALER=8.
- TX 0xA5: txv=1 with cts=1 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles; cts low for exactly 80 cycles; second txv on the cts-rise cycle gives a gapless 160-cycle stream.
- RX 0x3C (tx looped to rx): rxv one cycle, rxd=0x3C, ferr=0. With parity enabled and the parity bit flipped: rxv and perr together, rxd=0x3C.
- rx low for 2 cycles only: no rxv, no ferr, RX remains idle. txv while cts=0: tx stays 1, byte dropped.
- Frame 0x55 with stop bit 0, line then held low 50 cycles: ferr one cycle, no rxv; no new frame starts until the line returns high.
- After rxv, line held high: eof exactly once at 280 cycles of silence. Start bit at silence count 270: no eof, counter cleared.
- rst=0 asserted mid-TX at bit 4: tx=1 and cts=0 immediately; cts=1 one cycle after release; next byte transmits correctly.
